// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates 1/5/10 coin credit against a per-product
// price table, vends with change, refunds on cancel or inactivity, rejects overflowing coins.
module vending_machine_multi #(
    parameter int NUM_PRODUCTS   = 4,
    parameter int CREDIT_W       = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int MAX_CREDIT     = 99,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coin1,
    input  logic                    coin5,
    input  logic                    coin10,
    input  logic [NUM_PRODUCTS-1:0] sel,
    input  logic                    cancel,
    output logic                    dispense,
    output logic                    refund,
    output logic [ID_W-1:0]         product_id,
    output logic [CREDIT_W-1:0]     change,
    output logic                    change_valid,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    coin_reject,
    output logic                    busy
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic [ID_W-1:0]     product_id_next;
    logic [CNT_W-1:0]    timer, timer_next;
    logic                coin_rejected;

    logic                dispense_next, refund_next, change_valid_next, busy_next;
    logic [CREDIT_W-1:0] change_next;

    logic [ID_W-1:0]     sel_index;
    logic [CREDIT_W-1:0] sel_price, cur_price;
    logic                sel_valid;
    logic                coin_any;
    logic [SUM_W-1:0]    coin_sum, credit_sum;
    logic                over_max, reach_price, timer_done;

    // Price lookups for the requested product and for the latched transaction product.
    always_comb begin
        sel_index = '0;
        sel_price = '0;
        cur_price = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel[i]) begin
                sel_index = ID_W'(i);
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
            if (product_id == ID_W'(i)) begin
                cur_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign sel_valid   = $onehot(sel) && (sel_price != '0);
    assign coin_any    = coin1 | coin5 | coin10;
    assign coin_sum    = (coin1  ? SUM_W'(1)  : '0)
                       + (coin5  ? SUM_W'(5)  : '0)
                       + (coin10 ? SUM_W'(10) : '0);
    assign credit_sum  = {1'b0, credit} + coin_sum;
    assign over_max    = credit_sum > SUM_W'(MAX_CREDIT);
    assign reach_price = credit_sum >= {1'b0, cur_price};
    assign timer_done  = timer == CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            product_id   <= '0;
            timer        <= '0;
            dispense     <= 1'b0;
            refund       <= 1'b0;
            change_valid <= 1'b0;
            change       <= '0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            product_id   <= product_id_next;
            timer        <= timer_next;
            dispense     <= dispense_next;
            refund       <= refund_next;
            change_valid <= change_valid_next;
            change       <= change_next;
            coin_reject  <= coin_rejected;
            busy         <= busy_next;
        end
    end

    // Coins are only ever credited in COLLECT; every other path hands them back.
    always_comb begin
        state_next      = state;
        credit_next     = credit;
        product_id_next = product_id;
        timer_next      = timer;
        coin_rejected   = 1'b0;
        case (state)
            IDLE: begin
                credit_next   = '0;
                coin_rejected = coin_any;
                if (sel_valid) begin
                    state_next      = COLLECT;
                    product_id_next = sel_index;
                    timer_next      = '0;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    coin_rejected = coin_any;
                    state_next    = REFUND;
                end else if (coin_any && !over_max) begin
                    credit_next = credit_sum[CREDIT_W-1:0];
                    timer_next  = '0;
                    if (reach_price) begin
                        state_next = VEND;
                    end
                end else begin
                    coin_rejected = coin_any;
                    if (timer_done) begin
                        state_next = REFUND;
                    end else begin
                        timer_next = timer + CNT_W'(1);
                    end
                end
            end
            VEND, REFUND: begin
                coin_rejected = coin_any;
                credit_next   = '0;
                state_next    = IDLE;
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    // Change is held between pulses so the change bus only toggles on a vend or refund.
    always_comb begin
        dispense_next     = (state == VEND);
        refund_next       = (state == REFUND);
        change_valid_next = (state == VEND) || (state == REFUND);
        change_next       = change;
        if (state == VEND) begin
            change_next = credit - cur_price;
        end else if (state == REFUND) begin
            change_next = credit;
        end
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench: each scenario queues expected registered outputs per driven cycle
// and compares them one clock later against the default machine or a 99-price variant.
module tb_vending_machine_multi;

    typedef struct packed {
        logic       dispense;
        logic       refund;
        logic       cv;
        logic       rej;
        logic       busy;
        logic [7:0] credit;
        logic [1:0] pid;
        logic [7:0] change;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       c1;
        logic       c5;
        logic       c10;
        logic [3:0] sel;
        logic       cancel;
        obs_t       exp;
    } step_t;

    localparam int C1  = 1;
    localparam int C5  = 2;
    localparam int C10 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin1 = 1'b0, coin5 = 1'b0, coin10 = 1'b0, cancel = 1'b0;
    logic [3:0] sel = 4'b0000;

    logic       dispense_a, refund_a, change_valid_a, coin_reject_a, busy_a;
    logic [1:0] product_id_a;
    logic [7:0] change_a, credit_a;
    logic       dispense_b, refund_b, change_valid_b, coin_reject_b, busy_b;
    logic [1:0] product_id_b;
    logic [7:0] change_b, credit_b;
    obs_t       obs_a, obs_b;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    vending_machine_multi dut (
        .clk(clk), .rst(rst), .coin1(coin1), .coin5(coin5), .coin10(coin10),
        .sel(sel), .cancel(cancel), .dispense(dispense_a), .refund(refund_a),
        .product_id(product_id_a), .change(change_a), .change_valid(change_valid_a),
        .credit(credit_a), .coin_reject(coin_reject_a), .busy(busy_a)
    );

    // Product 3 costs exactly MAX_CREDIT; product 1 is disabled.
    vending_machine_multi #(
        .PRICES({8'd99, 8'd20, 8'd0, 8'd10})
    ) dut_max (
        .clk(clk), .rst(rst), .coin1(coin1), .coin5(coin5), .coin10(coin10),
        .sel(sel), .cancel(cancel), .dispense(dispense_b), .refund(refund_b),
        .product_id(product_id_b), .change(change_b), .change_valid(change_valid_b),
        .credit(credit_b), .coin_reject(coin_reject_b), .busy(busy_b)
    );

    assign obs_a = {dispense_a, refund_a, change_valid_a, coin_reject_a, busy_a,
                    credit_a, product_id_a, change_a};
    assign obs_b = {dispense_b, refund_b, change_valid_b, coin_reject_b, busy_b,
                    credit_b, product_id_b, change_b};

    function automatic obs_t mk(int d, int r, int cv, int rej, int bsy, int cr, int pid, int ch);
        obs_t o;
        o.dispense = d[0];
        o.refund   = r[0];
        o.cv       = cv[0];
        o.rej      = rej[0];
        o.busy     = bsy[0];
        o.credit   = 8'(cr);
        o.pid      = 2'(pid);
        o.change   = 8'(ch);
        return o;
    endfunction

    function automatic step_t stp(int rs, int coins, logic [3:0] s, int cn, obs_t e);
        step_t st;
        st.rst    = rs[0];
        st.c1     = coins[0];
        st.c5     = coins[1];
        st.c10    = coins[2];
        st.sel    = s;
        st.cancel = cn[0];
        st.exp    = e;
        return st;
    endfunction

    task automatic apply_stimulus(input step_t s);
        rst    = s.rst;
        coin1  = s.c1;
        coin5  = s.c5;
        coin10 = s.c10;
        sel    = s.sel;
        cancel = s.cancel;
    endtask

    task automatic test_reset();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(1, 0,   4'b0000, 0, mk(0,0,0,0,0,0,0,0)));
        s.push_back(stp(1, C10, 4'b0001, 0, mk(0,0,0,0,0,0,0,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL reset[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_vend_exact();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,  4'b0001, 0, mk(0,0,0,0,1,0,0,0)));
        s.push_back(stp(0, C5, 4'b0000, 0, mk(0,0,0,0,1,5,0,0)));
        s.push_back(stp(0, C5, 4'b0000, 0, mk(0,0,0,0,1,10,0,0)));
        s.push_back(stp(0, 0,  4'b0000, 0, mk(1,0,1,0,0,0,0,0)));
        s.push_back(stp(0, 0,  4'b0000, 0, mk(0,0,0,0,0,0,0,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL vend_exact[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_vend_change();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,   4'b1000, 0, mk(0,0,0,0,1,0,3,0)));
        s.push_back(stp(0, C10, 4'b0000, 0, mk(0,0,0,0,1,10,3,0)));
        s.push_back(stp(0, C10, 4'b0000, 0, mk(0,0,0,0,1,20,3,0)));
        s.push_back(stp(0, C10, 4'b0000, 0, mk(0,0,0,0,1,30,3,0)));
        s.push_back(stp(0, 0,   4'b0000, 0, mk(1,0,1,0,0,0,3,5)));
        s.push_back(stp(0, 0,   4'b0000, 0, mk(0,0,0,0,0,0,3,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL vend_change[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_cancel();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,   4'b0010, 0, mk(0,0,0,0,1,0,1,0)));
        s.push_back(stp(0, C5,  4'b0000, 0, mk(0,0,0,0,1,5,1,0)));
        s.push_back(stp(0, C10, 4'b0000, 1, mk(0,0,0,1,1,5,1,0)));
        s.push_back(stp(0, 0,   4'b0000, 0, mk(0,1,1,0,0,0,1,5)));
        s.push_back(stp(0, 0,   4'b0000, 0, mk(0,0,0,0,0,0,1,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL cancel[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    // The machine sits in COLLECT for 64 edges after the coin, enters REFUND, and pulses next.
    task automatic test_timeout();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,  4'b0100, 0, mk(0,0,0,0,1,0,2,0)));
        s.push_back(stp(0, C1, 4'b0000, 0, mk(0,0,0,0,1,1,2,0)));
        for (int j = 0; j < 64; j++) begin
            s.push_back(stp(0, 0, 4'b0000, 0, mk(0,0,0,0,1,1,2,0)));
        end
        s.push_back(stp(0, 0, 4'b0000, 0, mk(0,1,1,0,0,0,2,1)));
        s.push_back(stp(0, 0, 4'b0000, 0, mk(0,0,0,0,0,0,2,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL timeout[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_idle();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,   4'b0011, 0, mk(0,0,0,0,0,0,2,0)));
        s.push_back(stp(0, C10, 4'b0000, 0, mk(0,0,0,1,0,0,2,0)));
        s.push_back(stp(0, 0,   4'b0000, 1, mk(0,0,0,0,0,0,2,0)));
        s.push_back(stp(0, C1,  4'b0001, 0, mk(0,0,0,1,1,0,0,0)));
        s.push_back(stp(0, 0,   4'b0000, 1, mk(0,0,0,0,1,0,0,0)));
        s.push_back(stp(0, 0,   4'b0000, 0, mk(0,1,1,0,0,0,0,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL idle[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,        4'b0001, 0, mk(0,0,0,0,1,0,0,0)));
        s.push_back(stp(0, C10,      4'b0000, 0, mk(0,0,0,0,1,10,0,0)));
        s.push_back(stp(0, C1,       4'b0001, 0, mk(1,0,1,1,0,0,0,0)));
        s.push_back(stp(0, 0,        4'b1000, 0, mk(0,0,0,0,1,0,3,0)));
        s.push_back(stp(0, C10 + C5, 4'b0000, 0, mk(0,0,0,0,1,15,3,0)));
        s.push_back(stp(0, C10,      4'b0000, 0, mk(0,0,0,0,1,25,3,0)));
        s.push_back(stp(0, 0,        4'b0000, 0, mk(1,0,1,0,0,0,3,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_rst_mid();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0,   4'b1000, 0, mk(0,0,0,0,1,0,3,0)));
        s.push_back(stp(0, C10, 4'b0000, 0, mk(0,0,0,0,1,10,3,0)));
        s.push_back(stp(1, 0,   4'b0000, 0, mk(0,0,0,0,0,0,0,0)));
        s.push_back(stp(0, 0,   4'b0000, 0, mk(0,0,0,0,0,0,0,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_a;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL rst_mid[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_overflow();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0, 4'b1000, 0, mk(0,0,0,0,1,0,3,0)));
        for (int k = 1; k <= 9; k++) begin
            s.push_back(stp(0, C10, 4'b0000, 0, mk(0,0,0,0,1,10*k,3,0)));
        end
        s.push_back(stp(0, C10 + C1, 4'b0000, 0, mk(0,0,0,1,1,90,3,0)));
        s.push_back(stp(0, C5,       4'b0000, 0, mk(0,0,0,0,1,95,3,0)));
        for (int k = 1; k <= 4; k++) begin
            s.push_back(stp(0, C1, 4'b0000, 0, mk(0,0,0,0,1,95+k,3,0)));
        end
        s.push_back(stp(0, 0, 4'b0000, 0, mk(1,0,1,0,0,0,3,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_b;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL overflow[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_disabled();
        step_t s[$];
        obs_t  e, o;
        s.push_back(stp(0, 0, 4'b0010, 0, mk(0,0,0,0,0,0,3,0)));
        s.push_back(stp(0, 0, 4'b0100, 0, mk(0,0,0,0,1,0,2,0)));
        s.push_back(stp(0, 0, 4'b0000, 1, mk(0,0,0,0,1,0,2,0)));
        s.push_back(stp(0, 0, 4'b0000, 0, mk(0,1,1,0,0,0,2,0)));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = obs_b;
            if (!e.cv) o.change = e.change;
            total++;
            if (o !== e) begin bad++; $display("[TB] FAIL disabled[%0d]: got %h expected %h", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_cancel();
        test_timeout();
        test_idle();
        test_back_to_back();
        test_rst_mid();
        test_overflow();
        test_disabled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised multi-product vending controller that accepts 1/5/10-unit coin pulses against a per-product price table. It dispenses with change, refunds on cancel or inactivity timeout, and rejects coins that would overflow the credit register. It sits between the coin-acceptor/keypad front end and the dispense/change actuators, and generalises the fixed three-product controller to N products with cancel, timeout and coin-reject behaviour.

## Interface
- NUM_PRODUCTS, 4, number of selectable products (≥1)
- CREDIT_W, 8, width of credit, price and change values
- PRICES, {8'd25,8'd20,8'd15,8'd10}, packed price table; product i price = PRICES[i*CREDIT_W +: CREDIT_W]; price 0 = product disabled
- MAX_CREDIT, 99, largest credit the machine holds (< 2^CREDIT_W)
- TIMEOUT_CYCLES, 64, idle cycles in COLLECT before automatic refund (≥2)
- ID_W, $clog2(NUM_PRODUCTS) (min 1), width of product_id

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- coin1 / coin5 / coin10  in  1 each  one-cycle coin pulses; may coincide
- sel  in  NUM_PRODUCTS  product request, one-hot, sampled every cycle
- cancel  in  1  one-cycle cancel request
- dispense  out  1  one-cycle pulse, product released
- refund  out  1  one-cycle pulse, credit returned without vend
- product_id  out  ID_W  product latched for the current transaction
- change  out  CREDIT_W  amount returned; valid only while change_valid=1
- change_valid  out  1  one-cycle pulse with dispense or refund
- credit  out  CREDIT_W  current accumulated credit
- coin_reject  out  1  one-cycle pulse, coins sampled on the previous edge were returned
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, COLLECT, VEND, REFUND. All outputs are registered.
- IDLE:
  - credit=0.
  - sel with exactly one bit set and nonzero price: latch index into product_id, go to COLLECT.
  - sel zero, multi-hot, or naming a disabled product: ignored.
  - Any coin in IDLE: coin_reject pulse, no credit.
- COLLECT:
  - Per cycle, sum = coin1*1 + coin5*5 + coin10*10. Simultaneous coins are summed. Compute at CREDIT_W+1 bits.
  - cancel has priority: go to REFUND. Any coins in the same cycle are rejected (coin_reject), not credited.
  - If credit+sum > MAX_CREDIT: whole cycle's coins rejected, credit unchanged.
  - Otherwise credit += sum. If new credit ≥ price, go to VEND.
  - sel is ignored in COLLECT; the product cannot be changed.
- Timeout:
  - The counter clears on entry to COLLECT and on every accepted coin, and increments on every other COLLECT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with no coin accepted, go to REFUND.
- VEND (one cycle):
  - Assert dispense=1, change_valid=1, change=credit−price.
  - Then clear credit and go to IDLE.
- REFUND (one cycle):
  - Assert refund=1, change_valid=1, change=credit (0 allowed).
  - Then clear credit and go to IDLE.
- Inputs in VEND/REFUND: coins are rejected (coin_reject), sel and cancel ignored.

## Timing
- Reset values: state=IDLE, credit=0, product_id=0, change=0. dispense, refund, change_valid, coin_reject and busy are all 0.
- rst mid-transaction: credit is discarded with no refund pulse, and the state is IDLE after the edge.
- sel→COLLECT: busy=1 in the cycle after the sampling edge.
- Completing coin sampled at edge k: dispense/change_valid high for the cycle after edge k+1. credit shows the final sum after edge k and 0 after edge k+1.
- Vend throughput: one vend per ≥3 cycles (select, coin, vend).
- coin_reject is high for exactly the cycle after the edge that sampled the rejected coin(s).
- Timeout refund: REFUND is entered TIMEOUT_CYCLES cycles after the last accepted coin or the COLLECT entry.
- change is held at its last value outside change_valid; consumers must qualify it with change_valid.

## Test plan
- Select product 0 (price 10), coin5, coin5 → dispense=1, change=0, product_id=0, one cycle after the second coin's edge.
- Select product 3 (price 25), coin10×3 → dispense=1, change=5; credit reads 10, 20, 30, then 0.
- Select product 1 (price 15), coin5, then cancel together with coin10 → coin_reject=1, refund=1, change=5, no dispense.
- Select product 2, coin1, then no activity for 64 cycles → refund=1, change=1 exactly 64 cycles after the coin.
- Overflow with PRICES entry = 99 and MAX_CREDIT=99: insert nine coin10 (credit 90), then coin10+coin1 in one cycle (sum 11) → credit would reach 101 > 99, so coin_reject=1 and credit stays 90. Then coin5, coin1 ×4 → credit reaches 99 ≥ 99 → dispense=1, change=0.
- Idle-state cases: multi-hot sel=4'b0011 → stays IDLE, busy=0; coin10 in IDLE → coin_reject=1, credit=0. Assert rst while COLLECT holds credit 10 → next cycle IDLE with credit=0, refund=0.
